// File: rtl/pipe_seq_pkg.sv
// Shared types and constants for the pipeline phase sequencer.
// The default 6-stage core layout and its wait mask live here.
package pipe_seq_pkg;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_e;

    localparam int unsigned CORE_NUM_STAGES = 6;

    // Stage indices of the 6-stage core
    localparam int unsigned STG_FETCH_REQ = 0;
    localparam int unsigned STG_FETCH_RSP = 1;
    localparam int unsigned STG_DECODE    = 2;
    localparam int unsigned STG_SETUP     = 3;
    localparam int unsigned STG_EXECUTE   = 4;
    localparam int unsigned STG_WRITEBACK = 5;

    // Fetch-receive waits for memory; every other stage is single-cycle
    localparam logic [CORE_NUM_STAGES-1:0] DEFAULT_WAIT_MASK = 6'b000010;

endpackage

// File: rtl/pipe_seq_onehot_dec.sv
// Index-to-one-hot decoder with enable; out-of-range indices decode to all zero.
module pipe_seq_onehot_dec #(
    parameter int unsigned N  = 6,
    parameter int unsigned IW = 3
) (
    input  logic          en,
    input  logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (en && (idx == IW'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Parametrised pipeline phase sequencer: one-hot stage strobes with stall, wait-for-done,
// flush, halt-at-boundary and retire. Define PIPE_SEQ_PERF_CNT_EN for retire/stall counters.
module pipeline_sequencer
    import pipe_seq_pkg::*;
#(
    parameter int unsigned             NUM_STAGES = CORE_NUM_STAGES,
    parameter logic [NUM_STAGES-1:0]   WAIT_MASK  = NUM_STAGES'(DEFAULT_WAIT_MASK),
    parameter int unsigned             IDX_W      = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt_req,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_onehot,
    output logic [IDX_W-1:0]      stage_idx,
    output logic                  running,
    output logic                  retire,
    output logic                  halted
`ifdef PIPE_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]           retire_count,
    output logic [31:0]           stall_count
`endif
);

    seq_state_e       state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic             retire_next;
    logic             halted_next;
    logic             halt_pending, halt_pending_next;
    logic             idx_legal;
    logic             idx_last;
    logic             stage_complete;

    assign idx_legal = ({1'b0, idx} < (IDX_W+1)'(NUM_STAGES));
    assign idx_last  = (idx == IDX_W'(NUM_STAGES - 1));

    // Completion of the current stage: non-wait stages finish in one cycle
    always_comb begin
        stage_complete = 1'b0;
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            if (idx == IDX_W'(i)) begin
                stage_complete = !WAIT_MASK[i] || stage_done[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SEQ_IDLE;
            idx          <= '0;
            retire       <= 1'b0;
            halted       <= 1'b0;
            halt_pending <= 1'b0;
        end else begin
            state        <= state_next;
            idx          <= idx_next;
            retire       <= retire_next;
            halted       <= halted_next;
            halt_pending <= halt_pending_next;
        end
    end

    always_comb begin
        state_next        = state;
        idx_next          = idx;
        retire_next       = 1'b0;
        halted_next       = halted;
        halt_pending_next = halt_pending;

        case (state)
            SEQ_IDLE: begin
                idx_next = '0;
                if (start) begin
                    state_next  = SEQ_RUN;
                    halted_next = 1'b0;
                end
            end
            SEQ_RUN: begin
                if (halt_req) begin
                    halt_pending_next = 1'b1;
                end
                if (!idx_legal) begin
                    idx_next = '0;
                end else if (flush) begin
                    idx_next = '0;
                end else if (stall || !stage_complete) begin
                    idx_next = idx;
                end else if (!idx_last) begin
                    idx_next = idx + IDX_W'(1);
                end else begin
                    // Instruction boundary: retire, then wrap or stop
                    retire_next = 1'b1;
                    idx_next    = '0;
                    if (halt_pending || halt_req) begin
                        state_next        = SEQ_IDLE;
                        halted_next       = 1'b1;
                        halt_pending_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = SEQ_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    assign running   = (state == SEQ_RUN);
    assign stage_idx = idx;

    pipe_seq_onehot_dec #(
        .N  (NUM_STAGES),
        .IW (IDX_W)
    ) u_dec (
        .en     (running),
        .idx    (idx),
        .onehot (stage_onehot)
    );

`ifdef PIPE_SEQ_PERF_CNT_EN
    logic stall_cycle;

    // A held stage counts; flush and SEU recovery cycles do not
    assign stall_cycle = running && idx_legal && !flush && (stall || !stage_complete);

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_count <= '0;
            stall_count  <= '0;
        end else begin
            if (retire_next) begin
                retire_count <= retire_count + 32'd1;
            end
            if (stall_cycle) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Parametrised successor to the fixed 6-state pipeline phase controller.
- Generates a one-hot phase strobe per pipeline stage, using a configurable stage count.
- Adds idle/run control, a global stall, per-stage wait-for-done handshakes, flush-to-stage-0, halt-at-boundary and a retire pulse.
- Sits between top-level core control and the fetch/decode/setup/execute/writeback datapath enables.

Parameters:
- NUM_STAGES, 6: number of sequential stages; legal range 2..16.
- WAIT_MASK, 6'b000010: bit i = 1 means stage i holds until stage_done[i]. Width is NUM_STAGES. The default makes fetch-receive wait for memory.
- IDX_W, $clog2(NUM_STAGES): width of the stage index. Derived; do not override.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  leave IDLE and begin at stage 0
- halt_req  in  1  request stop at the next instruction boundary
- stall  in  1  freeze the current stage
- flush  in  1  abandon the current instruction and restart at stage 0
- stage_done  in  NUM_STAGES  per-stage completion; only bits set in WAIT_MASK are used
- stage_onehot  out  NUM_STAGES  one-hot active stage; all zero in IDLE
- stage_idx  out  IDX_W  current stage index; 0 in IDLE
- running  out  1  high in RUN
- retire  out  1  one-cycle pulse when the last stage completes
- halted  out  1  high in IDLE after a halt-initiated stop, until the next start

Behaviour:
- FSM states: IDLE and RUN. In RUN, a registered stage counter idx is in 0..NUM_STAGES-1.
- Reset values: state=IDLE, idx=0, retire=0, halted=0, halt_pending=0. All outputs are therefore 0.
- IDLE:
  - start=1 moves to RUN with idx=0 on the next edge, and clears halted.
  - stall, flush and stage_done are ignored in IDLE.
- RUN, per edge, in this priority order:
  1. flush: idx<=0, no retire, halt_pending kept.
  2. stall: hold idx.
  3. Stage not complete: hold idx. A stage is complete when WAIT_MASK[idx]=0, or when stage_done[idx]=1.
  4. Stage complete and idx<NUM_STAGES-1: idx<=idx+1.
  5. Stage complete and idx==NUM_STAGES-1:
     - retire<=1 for one cycle.
     - If halt_pending or halt_req: state<=IDLE, halted<=1, halt_pending<=0.
     - Otherwise idx<=0 (wrap).
- halt_req sets halt_pending while in RUN. The stop takes effect only at the instruction boundary, never mid-instruction.
- Latency and throughput:
  - The stage advances one cycle after the complete condition is seen.
  - With no waits and no stalls, one instruction takes exactly NUM_STAGES cycles.
  - retire is registered, so it is high in the cycle where stage_onehot[0] is high again, or in the first IDLE cycle after a halt.
- stage_onehot = (1 << idx) when running, else 0. It is decoded combinationally from registered state and is glitch-safe for enable use.
- Illegal idx (>= NUM_STAGES, reachable only through an SEU): the next edge forces idx=0. stage_onehot is all zero while illegal.
- stage_done bits for non-wait stages are don't-care. A stage_done bit that arrives while stall=1 is not remembered; the upstream holds done until the stage advances.
- Simultaneous start and reset: reset wins.
- reset mid-RUN: IDLE next edge, no retire.

Optional Feature:
- PIPE_SEQ_PERF_CNT_EN defined:
  - Adds output ports retire_count[31:0] and stall_count[31:0].
  - retire_count increments on each retire pulse.
  - stall_count increments on each RUN cycle in which the stage does not advance because of stall or a missing done; flush cycles are not counted.
  - Both counters wrap at 2^32 and clear on reset only.
- Macro undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_seq_pkg holds:
  - the state enum (SEQ_IDLE, SEQ_RUN);
  - named stage-index constants for the 6-stage core (STG_FETCH_REQ=0 .. STG_WRITEBACK=5);
  - the default WAIT_MASK constant.
- One natural sub-module: pipe_seq_onehot_dec, a parametrised index-to-one-hot decoder with an enable input.

Test Plan:
1. Defaults, start pulse, stage_done[1] held high, no stall:
   - stage_onehot steps 000001..100000, 1 cycle each.
   - retire pulses every 6 cycles.
   - running=1 throughout.
2. stage_done[1] low for 3 cycles, then high:
   - Stage 1 holds for 3 extra cycles, then advances.
   - The instruction takes 9 cycles.
   - With PIPE_SEQ_PERF_CNT_EN, stall_count=3.
3. stall high for 2 cycles at idx=3, then flush at idx=4:
   - idx stays 3 for 2 cycles, reaches 4, then returns to 0 on the next edge.
   - No retire pulse.
4. halt_req pulsed at idx=2:
   - The sequence continues to idx=5 and completes.
   - Next cycle: retire=1, running=0, halted=1, stage_onehot=0.
   - A later start resumes at idx=0 and clears halted.
5. reset asserted at idx=4 with start=1:
   - Next cycle: IDLE, all outputs 0, no retire.
6. NUM_STAGES=4, WAIT_MASK=4'b0000:
   - Period is 4 cycles, with stage_onehot 0001, 0010, 0100, 1000.
   - stage_idx wraps 3 to 0.
   - retire_count=10 after 40 cycles of RUN.
